// File: rtl/uart_mmio_pkg.sv
// uart_mmio_pkg: register offsets, status bit positions and FSM state types for the UART slave
package uart_mmio_pkg;
    localparam logic [1:0] UART_REG_DATA   = 2'd0;
    localparam logic [1:0] UART_REG_STATUS = 2'd1;
    localparam logic [1:0] UART_REG_COUNT  = 2'd2;
    localparam int UART_ST_RX_READY = 0;
    localparam int UART_ST_TX_BUSY  = 1;
    localparam int UART_ST_OVERRUN  = 2;
    localparam int UART_ST_FRAMING  = 3;
    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} t_uart_tx_state;
    typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAIT} t_uart_rx_state;
endpackage

// File: rtl/uart_fifo.sv
// uart_fifo: synchronous FIFO with wrapping pointers and a separate occupancy count
module uart_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     i_push,
    input  logic                     i_pop,
    input  logic [WIDTH-1:0]         i_data,
    output logic [WIDTH-1:0]         o_data,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);
    localparam int AW = $clog2(DEPTH);
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_push;
    logic             w_pop;
    assign o_full  = r_count == (AW+1)'(DEPTH);
    assign o_empty = r_count == '0;
    assign o_count = r_count;
    assign o_data  = r_mem[r_rd_ptr];
    assign w_push  = i_push & (~o_full | i_pop);
    assign w_pop   = i_pop & ~o_empty;
    // pointers and count; a push and pop together leave the count unchanged
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop) r_rd_ptr <= r_rd_ptr + AW'(1);
            r_count <= r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
        end
    end
    // storage needs no reset; empty entries are never presented
    always_ff @(posedge clock) begin
        if (w_push) r_mem[r_wr_ptr] <= i_data;
    end
endmodule

// File: rtl/uart_mmio.sv
// uart_mmio: zero-wait-state memory-mapped UART with TX shifter, RX sampler, RX FIFO and level IRQ
module uart_mmio
    import uart_mmio_pkg::*;
#(
    parameter int CLOCK_HZ      = 50_000_000,
    parameter int BAUD          = 115200,
    parameter int RX_FIFO_DEPTH = 16
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        select,
    input  logic [1:0]  address,
    input  logic [31:0] data_in,
    output logic [31:0] data_out,
    input  logic [3:0]  data_strobes,
    input  logic        read,
    input  logic        write,
    output logic        tx,
    input  logic        rx,
    output logic        irq
);
    localparam int BIT_TICKS = CLOCK_HZ / BAUD;
    localparam int CW = $clog2(BIT_TICKS + 1);
    localparam int AW = $clog2(RX_FIFO_DEPTH);
    localparam logic [CW-1:0] TICK_LAST = CW'(BIT_TICKS - 1);
    localparam logic [CW-1:0] TICK_HALF = CW'(BIT_TICKS / 2 - 1);
    t_uart_tx_state r_tx_state, w_tx_state_next;
    t_uart_rx_state r_rx_state, w_rx_state_next;
    logic [CW-1:0] r_tx_cnt, w_tx_cnt_next, r_rx_cnt, w_rx_cnt_next;
    logic [2:0]    r_tx_bit, w_tx_bit_next, r_rx_bit, w_rx_bit_next;
    logic [7:0]    r_tx_shift, w_tx_shift_next, r_rx_shift, w_rx_shift_next;
    logic          r_tx, w_tx_line, r_rx_meta, r_rx_sync, r_overrun, r_framing;
    logic          w_wr, w_tx_load, w_st_clr, w_pop, w_push, w_rx_done, w_rx_bad;
    logic          w_full, w_empty;
    logic [7:0]    w_head;
    logic [AW:0]   w_count;
    logic [31:0]   w_status, w_rd_data;
    logic          w_unused;
    assign w_wr      = select & write & (data_strobes == 4'b1111);
    assign w_tx_load = w_wr & (address == UART_REG_DATA) & (r_tx_state == TX_IDLE);
    assign w_st_clr  = w_wr & (address == UART_REG_STATUS);
    assign w_pop     = select & read & (address == UART_REG_DATA) & ~w_empty;
    assign w_push    = w_rx_done & (~w_full | w_pop);
    assign tx        = r_tx;
    assign irq       = ~w_empty;
    assign w_unused  = &{1'b0, data_in[31:8]};
    uart_fifo #(.WIDTH(8), .DEPTH(RX_FIFO_DEPTH)) u_fifo (
        .clock   (clock),
        .reset   (reset),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_data  (r_rx_shift),
        .o_data  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );
    // TX state, bit timing and the registered line, which trails the FSM by one clock
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_tx_state <= TX_IDLE;
            r_tx_cnt   <= '0;
            r_tx_bit   <= '0;
            r_tx_shift <= '0;
            r_tx       <= 1'b1;
        end else begin
            r_tx_state <= w_tx_state_next;
            r_tx_cnt   <= w_tx_cnt_next;
            r_tx_bit   <= w_tx_bit_next;
            r_tx_shift <= w_tx_shift_next;
            r_tx       <= w_tx_line;
        end
    end
    // TX next state: each of START, 8 DATA bits and STOP lasts BIT_TICKS clocks
    always_comb begin
        w_tx_state_next = r_tx_state;
        w_tx_cnt_next   = r_tx_cnt + CW'(1);
        w_tx_bit_next   = r_tx_bit;
        w_tx_shift_next = r_tx_shift;
        w_tx_line       = 1'b1;
        case (r_tx_state)
            TX_IDLE: begin
                w_tx_cnt_next = '0;
                if (w_tx_load) begin
                    w_tx_state_next = TX_START;
                    w_tx_shift_next = data_in[7:0];
                end
            end
            TX_START: begin
                w_tx_line = 1'b0;
                if (r_tx_cnt == TICK_LAST) begin
                    w_tx_cnt_next   = '0;
                    w_tx_bit_next   = '0;
                    w_tx_state_next = TX_DATA;
                end
            end
            TX_DATA: begin
                w_tx_line = r_tx_shift[0];
                if (r_tx_cnt == TICK_LAST) begin
                    w_tx_cnt_next   = '0;
                    w_tx_shift_next = r_tx_shift >> 1;
                    w_tx_bit_next   = r_tx_bit + 3'd1;
                    w_tx_state_next = (r_tx_bit == 3'd7) ? TX_STOP : TX_DATA;
                end
            end
            TX_STOP: begin
                if (r_tx_cnt == TICK_LAST) begin
                    w_tx_cnt_next   = '0;
                    w_tx_state_next = TX_IDLE;
                end
            end
            default: w_tx_state_next = TX_IDLE;
        endcase
    end
    // RX synchroniser, RX state and sticky flags; a same-edge set beats a W1C clear
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_rx_meta  <= 1'b1;
            r_rx_sync  <= 1'b1;
            r_rx_state <= RX_IDLE;
            r_rx_cnt   <= '0;
            r_rx_bit   <= '0;
            r_rx_shift <= '0;
            r_overrun  <= 1'b0;
            r_framing  <= 1'b0;
        end else begin
            r_rx_meta  <= rx;
            r_rx_sync  <= r_rx_meta;
            r_rx_state <= w_rx_state_next;
            r_rx_cnt   <= w_rx_cnt_next;
            r_rx_bit   <= w_rx_bit_next;
            r_rx_shift <= w_rx_shift_next;
            r_overrun  <= (w_rx_done & w_full & ~w_pop) | (r_overrun & ~(w_st_clr & data_in[UART_ST_OVERRUN]));
            r_framing  <= w_rx_bad | (r_framing & ~(w_st_clr & data_in[UART_ST_FRAMING]));
        end
    end
    // RX next state: half-bit start check, then mid-bit sampling of data and stop
    always_comb begin
        w_rx_state_next = r_rx_state;
        w_rx_cnt_next   = r_rx_cnt + CW'(1);
        w_rx_bit_next   = r_rx_bit;
        w_rx_shift_next = r_rx_shift;
        w_rx_done       = 1'b0;
        w_rx_bad        = 1'b0;
        case (r_rx_state)
            RX_IDLE: begin
                w_rx_cnt_next = '0;
                if (!r_rx_sync) w_rx_state_next = RX_START;
            end
            RX_START: begin
                if (r_rx_cnt == TICK_HALF) begin
                    w_rx_cnt_next   = '0;
                    w_rx_bit_next   = '0;
                    w_rx_state_next = r_rx_sync ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (r_rx_cnt == TICK_LAST) begin
                    w_rx_cnt_next   = '0;
                    w_rx_shift_next = {r_rx_sync, r_rx_shift[7:1]};
                    w_rx_bit_next   = r_rx_bit + 3'd1;
                    w_rx_state_next = (r_rx_bit == 3'd7) ? RX_STOP : RX_DATA;
                end
            end
            RX_STOP: begin
                if (r_rx_cnt == TICK_LAST) begin
                    w_rx_cnt_next   = '0;
                    w_rx_done       = r_rx_sync;
                    w_rx_bad        = ~r_rx_sync;
                    w_rx_state_next = r_rx_sync ? RX_IDLE : RX_WAIT;
                end
            end
            RX_WAIT: begin
                w_rx_cnt_next = '0;
                if (r_rx_sync) w_rx_state_next = RX_IDLE;
            end
            default: w_rx_state_next = RX_IDLE;
        endcase
    end
    // status word assembled from the flag positions
    always_comb begin
        w_status = '0;
        w_status[UART_ST_RX_READY] = ~w_empty;
        w_status[UART_ST_TX_BUSY]  = r_tx_state != TX_IDLE;
        w_status[UART_ST_OVERRUN]  = r_overrun;
        w_status[UART_ST_FRAMING]  = r_framing;
    end
    assign w_rd_data = (address == UART_REG_DATA)   ? {24'h0, w_empty ? 8'h00 : w_head} :
                       (address == UART_REG_STATUS) ? w_status :
                       (address == UART_REG_COUNT)  ? 32'(w_count) : 32'h0;
    assign data_out  = (select & read) ? w_rd_data : 32'h0;
endmodule

// File: tb/tb_uart_mmio.sv
// tb_uart_mmio: scoreboard bench; bus reads and TX frames are checked by monitors against queued expectations
module tb_uart_mmio;
    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        select = 1'b0;
    logic [1:0]  address = 2'd0;
    logic [31:0] data_in = 32'h0;
    logic [31:0] data_out;
    logic [3:0]  data_strobes = 4'h0;
    logic        read = 1'b0;
    logic        write = 1'b0;
    logic        tx;
    logic        rx = 1'b1;
    logic        irq;

    typedef struct {
        string       name;
        logic [31:0] data;
        bit          chk_irq;
        bit          irq;
    } exp_t;

    exp_t       sbq[$];
    logic [7:0] txq[$];
    int         checks = 0;
    int         errors = 0;

    uart_mmio #(.CLOCK_HZ(1_000_000), .BAUD(100_000), .RX_FIFO_DEPTH(16)) dut (
        .clock        (clock),
        .reset        (reset),
        .select       (select),
        .address      (address),
        .data_in      (data_in),
        .data_out     (data_out),
        .data_strobes (data_strobes),
        .read         (read),
        .write        (write),
        .tx           (tx),
        .rx           (rx),
        .irq          (irq)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic idle();
        @(negedge clock);
        select = 1'b0; read = 1'b0; write = 1'b0; data_strobes = 4'h0;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d, input logic [3:0] s);
        @(negedge clock);
        select = 1'b1; read = 1'b0; write = 1'b1; address = a; data_in = d; data_strobes = s;
    endtask

    task automatic rd(input string name, input logic [1:0] a, input logic [31:0] exp, input bit ci, input bit ei);
        exp_t e;
        @(negedge clock);
        select = 1'b1; read = 1'b1; write = 1'b0; address = a; data_strobes = 4'h0;
        e.name = name; e.data = exp; e.chk_irq = ci; e.irq = ei;
        sbq.push_back(e);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        rx = 1'b0;
        repeat (10) @(negedge clock);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (10) @(negedge clock);
        end
        rx = stop;
        repeat (10) @(negedge clock);
        rx = 1'b1;
        repeat (4) @(negedge clock);
    endtask

    // bus-read monitor: every selected read cycle is compared against the queue head
    initial forever begin
        exp_t e;
        @(negedge clock); #1;
        if (select && read) begin
            if (sbq.size() == 0) check("unexpected_read", 32'h1, 32'h0);
            else begin
                e = sbq.pop_front();
                check(e.name, data_out, e.data);
                if (e.chk_irq) check({e.name, "_irq"}, 32'(irq), 32'(e.irq));
            end
        end
    end

    // TX monitor: a falling line starts a 100-sample frame compared against the expected byte
    initial begin
        logic prev_tx = 1'b1;
        forever begin
            @(negedge clock); #1;
            if (!reset && prev_tx === 1'b1 && tx === 1'b0) begin
                logic [7:0] eb;
                bit         have, aborted;
                int         bad;
                logic       ebit;
                have = txq.size() != 0;
                eb = have ? txq[0] : 8'h00;
                aborted = 1'b0;
                bad = 0;
                for (int i = 0; i < 100; i++) begin
                    if (i > 0) begin @(negedge clock); #1; end
                    if (reset) begin aborted = 1'b1; break; end
                    ebit = (i < 10) ? 1'b0 : (i < 90) ? eb[(i - 10) / 10] : 1'b1;
                    if (tx !== ebit) bad++;
                end
                if (have) void'(txq.pop_front());
                if (!aborted) begin
                    check("tx_frame_expected", 32'(have), 32'h1);
                    check($sformatf("tx_frame_%h_bad_samples", eb), bad, 0);
                end
            end
            prev_tx = tx;
        end
    end

    initial begin
        // reset state
        repeat (3) @(negedge clock);
        #1;
        check("reset_tx", 32'(tx), 32'h1);
        check("reset_irq", 32'(irq), 32'h0);
        rd("reset_data", 2'd0, 32'h0, 1, 0);
        rd("reset_status", 2'd1, 32'h0, 0, 0);
        rd("reset_count", 2'd2, 32'h0, 0, 0);
        idle();
        reset = 1'b0;
        repeat (3) @(negedge clock);

        // 1 and 2: A5 frame, a second write during the frame is dropped
        txq.push_back(8'hA5);
        wr(2'd0, 32'h0000_00A5, 4'hF);
        idle(); #1;
        check("tx_latency_hold", 32'(tx), 32'h1);
        idle(); #1;
        check("tx_latency_fall", 32'(tx), 32'h0);
        rd("busy_early", 2'd1, 32'h2, 0, 0);
        idle();
        repeat (15) @(negedge clock);
        wr(2'd0, 32'h0000_003C, 4'hF);
        idle();
        rd("busy_after_drop", 2'd1, 32'h2, 0, 0);
        rd("reg3_reads_zero", 2'd3, 32'h0, 0, 0);
        idle();
        repeat (100) @(negedge clock);
        rd("idle_after_frame", 2'd1, 32'h0, 0, 0);
        idle();
        repeat (120) @(negedge clock);

        // 3: single received byte, read pops in the same cycle
        send_byte(8'h5A, 1'b1);
        rd("rx1_count", 2'd2, 32'h1, 1, 1);
        rd("rx1_data", 2'd0, 32'h0000_005A, 1, 1);
        rd("rx1_count_after", 2'd2, 32'h0, 1, 0);
        rd("rx1_empty_data", 2'd0, 32'h0, 1, 0);
        idle();

        // 4: overrun on the 17th byte, in-order drain, W1C clear
        for (int i = 1; i <= 17; i++) send_byte(8'h20 + 8'(i), 1'b1);
        rd("full_count", 2'd2, 32'h10, 1, 1);
        rd("full_status", 2'd1, 32'h5, 0, 0);
        for (int i = 1; i <= 16; i++) rd($sformatf("drain_%0d", i), 2'd0, 32'h20 + 32'(i), 0, 0);
        rd("drained_count", 2'd2, 32'h0, 1, 0);
        rd("overrun_sticky", 2'd1, 32'h4, 0, 0);
        wr(2'd1, 32'h4, 4'hF);
        rd("overrun_cleared", 2'd1, 32'h0, 0, 0);
        idle();

        // 5: framing error then a short glitch
        send_byte(8'h77, 1'b0);
        rd("framing_count", 2'd2, 32'h0, 1, 0);
        rd("framing_status", 2'd1, 32'h8, 0, 0);
        wr(2'd1, 32'h8, 4'hF);
        rd("framing_cleared", 2'd1, 32'h0, 0, 0);
        idle();
        rx = 1'b0;
        repeat (3) @(negedge clock);
        rx = 1'b1;
        repeat (30) @(negedge clock);
        rd("glitch_count", 2'd2, 32'h0, 1, 0);
        rd("glitch_status", 2'd1, 32'h0, 0, 0);
        idle();

        // 6: reset mid frame, then a partial-strobe write is ignored
        txq.push_back(8'hC3);
        wr(2'd0, 32'h0000_00C3, 4'hF);
        idle();
        repeat (30) @(negedge clock);
        reset = 1'b1;
        #1;
        check("reset_mid_tx", 32'(tx), 32'h1);
        rd("reset_mid_status", 2'd1, 32'h0, 1, 0);
        idle();
        reset = 1'b0;
        wr(2'd0, 32'h0000_0055, 4'b0001);
        rd("strobe_write_ignored", 2'd1, 32'h0, 0, 0);
        idle();
        repeat (120) @(negedge clock);
        #1;
        check("tx_idle_end", 32'(tx), 32'h1);
        check("sb_drained", sbq.size(), 0);
        check("tx_drained", txq.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
